if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage. Drives pc/inst into the decode stage. Runs a req/ack read handshake to
//  instruction memory, buffers fetched words in a small prefetch FIFO, honours downstream stall and
//  branch/jump redirect. Sits between instruction memory and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset; must be 4-byte aligned
//  FIFO_DEPTH  2              prefetch entries {pc,inst}; legal 1..4
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   reset, synchronous, active-high
//  mem_req_o      out  1   read request to instruction memory
//  mem_addr_o     out  32  read address, stable while mem_req_o high
//  mem_ack_i      in   1   transfer completes in any cycle with mem_req_o && mem_ack_i
//  mem_rdata_i    in   32  instruction word, valid only in the ack cycle
//  stall_i        in   1   decode cannot accept this cycle
//  redirect_i     in   1   pipeline redirect (branch/jump taken)
//  redirect_pc_i  in   32  redirect target; bits [1:0] ignored (forced 2'b00)
//  valid_o        out  1   pc_o/inst_o hold a real instruction
//  pc_o           out  32  pc of FIFO head
//  inst_o         out  32  instruction at FIFO head
// BEHAVIOUR
//  Reset: mem_req_o=0, mem_addr_o=RESET_PC, fetch_pc=RESET_PC, FIFO count=0, state IDLE,
//   valid_o=0, pc_o=32'h0, inst_o=32'h0000_0013 (addi x0,x0,0). rst overrides every other input;
//   an outstanding request is abandoned; the memory discards the transaction on reset.
//  Outputs: valid_o=(count!=0). Empty FIFO -> pc_o=0, inst_o=NOP. Pop at edge when valid_o && !stall_i.
//  Only one memory request is outstanding at a time. mem_req_o and mem_addr_o are registered.
//  FSM (mem_req_o=1 in BUSY and DROP):
//   IDLE: room := count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop this cycle.
//         room && !redirect_i -> BUSY, mem_addr_o<=fetch_pc.
//         redirect_i -> fetch_pc<=redirect_pc; stay IDLE. Next request issues the following cycle.
//   BUSY: ack && !redirect_i -> push {mem_addr_o,mem_rdata_i}, fetch_pc<=mem_addr_o+4.
//           If room remains after push and pop -> stay BUSY, mem_addr_o<=mem_addr_o+4 (back-to-back).
//           Otherwise -> IDLE.
//         !ack && redirect_i -> DROP, fetch_pc<=redirect_pc.
//         ack && redirect_i -> data discarded, fetch_pc<=redirect_pc, -> IDLE.
//         !ack && !redirect_i -> hold req/addr.
//   DROP: request held at old address until ack. Ack -> data discarded, -> IDLE.
//         Redirect in DROP updates fetch_pc; state stays DROP.
//  Redirect: FIFO flushed at the same edge, count<=0; flush beats push and pop; valid_o=0 next cycle.
//  Latency: ack cycle N -> entry visible on valid_o/pc_o/inst_o in cycle N+1.
//   Zero-wait memory sustains 1 instr/cycle.
//  FIFO: circular rd/wr pointers mod FIFO_DEPTH; push and pop in the same cycle leave count
//   unchanged. Overflow is impossible by issue rule (checked by assertion).
//  Address arithmetic: 32-bit, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
// TESTING
//  1 rst 2 cycles, ack tied 1, stall 0 -> mem_addr_o 0x0,0x4,0x8... on consecutive cycles;
//    valid_o=1 from 2nd cycle after req; pc_o 0x0,0x4,0x8 each cycle.
//  2 stall_i held 1 -> FIFO fills to 2, mem_req_o drops to 0, pc_o/inst_o frozen at 0x0.
//    Release -> fetching resumes at 0x8, no instruction lost or duplicated.
//  3 ack delayed 3 cycles on addr 0x8, redirect_i=1 to 0x100 in cycle 1 of wait -> req held at 0x8
//    until ack, data dropped. Next req addr 0x100; first valid pc_o=0x100.
//  4 redirect_i coincident with ack for 0x4, target 0x40 -> word for 0x4 never appears.
//    FIFO empty next cycle; next pc_o=0x40.
//  5 RESET_PC=32'hFFFF_FFF8, zero-wait -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 rst asserted while BUSY with 1 FIFO entry -> next cycle mem_req_o=0, valid_o=0, inst_o=0x13.
//    Then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decode stage.
// Memory: a read completes in any cycle with mem_req_o && mem_ack_i; req/addr stay stable until then.
// Decode: an entry is consumed at an edge where valid_o && !stall_i.
interface if_fetch_unit_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  modport master (
    output mem_req_o, mem_addr_o, valid_o, pc_o, inst_o,
    input  mem_ack_i, mem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, valid_o, pc_o, inst_o,
    output mem_ack_i, mem_rdata_i, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding req/ack memory reads feeding a small
// {pc,inst} prefetch FIFO, with decode stall and branch/jump redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_unit_if.master   bus,
  output logic [1:0]        o_dbg_state
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            r_state;
  logic              r_mem_req;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]       r_fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  state_e            w_state_n;
  logic              w_mem_req_n;
  logic [31:0]       w_mem_addr_n;
  logic [31:0]       w_fetch_pc_n;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic [CNT_W-1:0]  w_count_if_push;
  logic [31:0]       w_redirect_pc;
  logic [31:0]       w_addr_inc;

  assign w_valid         = (r_count != '0);
  assign w_pop           = w_valid && !bus.stall_i;
  assign w_room          = (r_count < DEPTH_C) || ((r_count == DEPTH_C) && w_pop);
  assign w_count_if_push = r_count + CNT_W'(1) - CNT_W'(w_pop);
  assign w_redirect_pc   = {bus.redirect_pc_i[31:2], 2'b00};
  assign w_addr_inc      = r_mem_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_n;
      r_mem_req  <= w_mem_req_n;
      r_mem_addr <= w_mem_addr_n;
      r_fetch_pc <= w_fetch_pc_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_mem_req_n  = r_mem_req;
    w_mem_addr_n = r_mem_addr;
    w_fetch_pc_n = r_fetch_pc;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect_i) begin
          w_fetch_pc_n = w_redirect_pc;
        end else if (w_room) begin
          w_state_n    = S_BUSY;
          w_mem_req_n  = 1'b1;
          w_mem_addr_n = r_fetch_pc;
        end
      end
      S_BUSY: begin
        if (bus.mem_ack_i && !bus.redirect_i) begin
          w_push       = 1'b1;
          w_fetch_pc_n = w_addr_inc;
          // Issue the next word straight away only if it is guaranteed a slot.
          if (w_count_if_push < DEPTH_C) begin
            w_mem_addr_n = w_addr_inc;
          end else begin
            w_state_n   = S_IDLE;
            w_mem_req_n = 1'b0;
          end
        end else if (bus.redirect_i) begin
          w_fetch_pc_n = w_redirect_pc;
          if (bus.mem_ack_i) begin
            w_state_n   = S_IDLE;
            w_mem_req_n = 1'b0;
          end else begin
            w_state_n = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (bus.redirect_i) w_fetch_pc_n = w_redirect_pc;
        if (bus.mem_ack_i) begin
          w_state_n   = S_IDLE;
          w_mem_req_n = 1'b0;
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_mem_req_n = 1'b0;
      end
    endcase
  end

  // A redirect flushes the FIFO and takes precedence over any push or pop that edge.
  always_ff @(posedge clk) begin
    if (rst || bus.redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= r_mem_addr;
        r_fifo_inst[r_wr_ptr] <= bus.mem_rdata_i;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (w_push && !w_pop) |-> (r_count < DEPTH_C));

  assign bus.mem_req_o  = r_mem_req;
  assign bus.mem_addr_o = r_mem_addr;
  assign bus.valid_o    = w_valid;
  assign bus.pc_o       = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign bus.inst_o     = w_valid ? r_fifo_inst[r_rd_ptr] : NOP;
  assign o_dbg_state    = r_state;
endmodule
